// File: rtl/onehot_stream_encoder_if.sv
// Handshake bundle for the one-hot stream encoder: vector input side and index output side.
interface onehot_stream_encoder_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero_seen;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, zero_seen
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, zero_seen
  );
endinterface

// File: rtl/onehot_stream_encoder.sv
// Accepts an N-bit request vector and streams out the index of every set bit,
// lowest first, one per beat; all-zero vectors are dropped with a zero_seen pulse.
module onehot_stream_encoder #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input logic                    clk,
  input logic                    rst,
  onehot_stream_encoder_if.slave bus
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  logic [N-1:0] pending;
  logic [N-1:0] remaining;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         zero_seen;

  function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // pending with the bit currently on out_idx already retired
  always_comb begin
    remaining = pending & ~({{(N-1){1'b0}}, 1'b1} << out_idx);
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid;
  assign bus.out_idx   = out_idx;
  assign bus.out_last  = out_last;
  assign bus.zero_seen = zero_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      zero_seen <= 1'b0;
    end else begin
      zero_seen <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_vec != '0) begin
              pending   <= bus.in_vec;
              out_idx   <= lowest_index(bus.in_vec);
              out_last  <= $onehot(bus.in_vec);
              out_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              zero_seen <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              pending   <= '0;
              state     <= IDLE;
            end else begin
              pending  <= remaining;
              out_idx  <= lowest_index(remaining);
              out_last <= $onehot(remaining);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_stream_encoder.sv
// Self-checking bench: directed cases plus random vectors, compared every cycle
// against a queue-of-indices model of the encoder.
module tb_onehot_stream_encoder;

  logic clk;
  logic rst;
  onehot_stream_encoder_if #(.N(8)) bus ();

  onehot_stream_encoder #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;
  int readyMode = 0;
  int expQ[$];
  bit expZero = 1'b0;
  int seen[$];
  int expSeen[$];
  int zeroPulses = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: an accepted vector becomes the ascending list of its set indices.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        if (expQ.size() != 0) begin
          checkOutput("out_valid", int'(bus.out_valid), 1);
          checkOutput("out_idx", int'(bus.out_idx), expQ[0]);
          checkOutput("out_last", int'(bus.out_last), int'(expQ.size() == 1));
          checkOutput("in_ready_busy", int'(bus.in_ready), 0);
        end else begin
          checkOutput("out_valid_idle", int'(bus.out_valid), 0);
          checkOutput("in_ready_idle", int'(bus.in_ready), int'(!rst));
        end
        checkOutput("zero_seen", int'(bus.zero_seen), int'(expZero));
        if (bus.zero_seen === 1'b1) zeroPulses++;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready) seen.push_back(int'(bus.out_idx));

        expZero = 1'b0;
        if (rst) begin
          expQ.delete();
        end else if (expQ.size() != 0) begin
          if (bus.out_ready) void'(expQ.pop_front());
        end else if (bus.in_valid) begin
          if (bus.in_vec == 8'h00) expZero = 1'b1;
          else for (int i = 0; i < 8; i++) if (bus.in_vec[i]) expQ.push_back(i);
        end
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Offers v until it is taken; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] v);
    bit accepted;
    accepted = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_vec = v;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = bus.in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_vec = 8'($urandom);
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = (bus.in_ready === 1'b1);
    end
    if (!idle) checkOutput("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkSeen(input string name);
    checkOutput({name, "_count"}, seen.size(), expSeen.size());
    for (int i = 0; i < expSeen.size() && i < seen.size(); i++)
      checkOutput(name, seen[i], expSeen[i]);
  endtask

  initial begin
    int zBefore;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_vec = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_out_idx", int'(bus.out_idx), 0);
    checkOutput("rst_out_last", int'(bus.out_last), 0);
    checkOutput("rst_zero_seen", int'(bus.zero_seen), 0);
    checkOutput("rst_in_ready", int'(bus.in_ready), 0);
    checking = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    seen.delete();
    readyMode = 0;
    applyStimulus(8'b0000_0001);
    waitIdle();
    expSeen = '{0};
    checkSeen("t1_beats");

    seen.delete();
    applyStimulus(8'hA5);
    waitIdle();
    expSeen = '{0, 2, 5, 7};
    checkSeen("t2_beats");

    seen.delete();
    readyMode = 1;
    applyStimulus(8'hFF);
    waitIdle();
    expSeen = '{0, 1, 2, 3, 4, 5, 6, 7};
    checkSeen("t3_beats");

    readyMode = 0;
    zBefore = zeroPulses;
    applyStimulus(8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_zero_pulses", zeroPulses - zBefore, 1);

    seen.delete();
    applyStimulus(8'hF0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("t5_rst_out_idx", int'(bus.out_idx), 0);
    rst = 1'b0;
    expSeen = '{4, 5};
    checkSeen("t5_beats");
    seen.delete();
    applyStimulus(8'h02);
    waitIdle();
    expSeen = '{1};
    checkSeen("t5_after");

    seen.delete();
    applyStimulus(8'h03);
    applyStimulus(8'h80);
    waitIdle();
    expSeen = '{0, 1, 7};
    checkSeen("t6_beats");

    readyMode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus(v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    waitIdle();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
